// File: rtl/mmu_job_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmu_sched_pkg
// Description : Shared types and constants for the MMU job scheduler.
//               It provides the scheduler state encoding and the sizes of the
//               operand and result transfers.
// Revision    : 1.0 - initial release
// ============================================================================
package mmu_sched_pkg;

  localparam int NUM_OPERAND_BYTES = 8;
  localparam int NUM_RESULT_BYTES  = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RST_MMU   = 3'd1,
    LOAD      = 3'd2,
    WAIT_DONE = 3'd3,
    CAPTURE   = 3'd4,
    RESPOND   = 3'd5
  } sched_state_e;

  // The same encodings as plain vectors, for the scheduler's state register.
  localparam logic [2:0] ST_IDLE      = IDLE;
  localparam logic [2:0] ST_RST_MMU   = RST_MMU;
  localparam logic [2:0] ST_LOAD      = LOAD;
  localparam logic [2:0] ST_WAIT_DONE = WAIT_DONE;
  localparam logic [2:0] ST_CAPTURE   = CAPTURE;
  localparam logic [2:0] ST_RESPOND   = RESPOND;

endpackage
`default_nettype wire

// File: rtl/mmu_job_scheduler_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter with a last-grant pointer.
//               - When both requesters are active, the requester that did not
//                 win last time is granted.
//               - The pointer updates only on a grant.
//               - After reset, requester 0 is favoured.
// Ports       : clk, rst   - clock, synchronous active-high reset
//               i_en       - grants are allowed this cycle
//               i_req[1:0] - request vector
//               o_gnt[1:0] - one-hot grant (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  // Requester that wins when both request.
  logic r_prio;

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      if (i_req == 2'b11) begin
        o_gnt = r_prio ? 2'b10 : 2'b01;
      end else begin
        o_gnt = i_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (|o_gnt) begin
      // Granting requester 0 hands the next tie to requester 1, and the reverse.
      r_prio <= o_gnt[0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mmu_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mmu_job_scheduler
// Description : Arbitrates two host requesters for one 2x2 matrix-multiply
//               unit. Each accepted job goes through these steps:
//               1. Reset the MMU control path.
//               2. Stream 8 operand bytes into operand memory.
//               3. Wait for mmu_done, with a timeout.
//               4. Capture 8 result bytes.
//               5. Return the result to the requester that won arbitration.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               req, operand0/1, transpose_req, gnt - requester side
//               mmu_rst, load_en, transpose, mem_we/waddr/wdata,
//               mmu_done, mmu_outdata    - MMU side
//               rsp_valid/ready/id/data/err, busy - response side
// Revision    : 1.0 - initial release
// ============================================================================
module mmu_job_scheduler
  import mmu_sched_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int TO_W        = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [63:0] operand0,
  input  logic [63:0] operand1,
  input  logic [1:0]  transpose_req,
  output logic [1:0]  gnt,
  output logic        mmu_rst,
  output logic        load_en,
  output logic        transpose,
  output logic        mem_we,
  output logic [2:0]  mem_waddr,
  output logic [7:0]  mem_wdata,
  input  logic        mmu_done,
  input  logic [7:0]  mmu_outdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [2:0]      c_LAST_OP  = 3'(NUM_OPERAND_BYTES - 1);
  localparam logic [2:0]      c_LAST_RES = 3'(NUM_RESULT_BYTES - 1);
  localparam logic [TO_W-1:0] c_TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  logic [2:0]      r_state;
  logic [63:0]     r_op;
  logic            r_transpose;
  logic            r_id;
  logic [2:0]      r_byte_cnt;
  logic [TO_W-1:0] r_to_cnt;
  logic [63:0]     r_rsp_data;
  logic            r_rsp_err;

  logic            w_grant_en;
  logic [1:0]      w_gnt;
  logic [2:0]      w_wbyte_sel;

  // No grant may be issued while reset is held, even though the state is
  // already IDLE.
  assign w_grant_en = (r_state == ST_IDLE) && !rst;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_grant_en),
    .i_req (req),
    .o_gnt (w_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_op        <= 64'd0;
      r_transpose <= 1'b0;
      r_id        <= 1'b0;
      r_byte_cnt  <= 3'd0;
      r_to_cnt    <= '0;
      r_rsp_data  <= 64'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_gnt) begin
            r_op        <= w_gnt[1] ? operand1 : operand0;
            r_transpose <= w_gnt[1] ? transpose_req[1] : transpose_req[0];
            r_id        <= w_gnt[1];
            r_rsp_data  <= 64'd0;
            r_rsp_err   <= 1'b0;
            r_state     <= ST_RST_MMU;
          end
        end
        ST_RST_MMU: begin
          r_byte_cnt <= 3'd0;
          r_state    <= ST_LOAD;
        end
        ST_LOAD: begin
          r_byte_cnt <= r_byte_cnt + 3'd1;
          if (r_byte_cnt == c_LAST_OP) begin
            r_to_cnt <= '0;
            r_state  <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (mmu_done) begin
            // Result bytes shift in from the bottom, so byte 0 ends up in [63:56].
            r_rsp_data <= {r_rsp_data[55:0], mmu_outdata};
            r_byte_cnt <= 3'd1;
            r_state    <= ST_CAPTURE;
          end else if (r_to_cnt == c_TO_LAST) begin
            r_rsp_err  <= 1'b1;
            r_rsp_data <= 64'd0;
            r_state    <= ST_RESPOND;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        ST_CAPTURE: begin
          // The stream is already running; mmu_done is not consulted here.
          r_rsp_data <= {r_rsp_data[55:0], mmu_outdata};
          r_byte_cnt <= r_byte_cnt + 3'd1;
          if (r_byte_cnt == c_LAST_RES) begin
            r_state <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          if (rsp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Address k carries byte k counted from the MSB end of the operand word.
  assign w_wbyte_sel = c_LAST_OP - r_byte_cnt;

  assign gnt       = w_gnt;
  assign busy      = (r_state != ST_IDLE);
  // The MMU control path stays in reset whenever no job owns it.
  assign mmu_rst   = (r_state == ST_IDLE) || (r_state == ST_RST_MMU);
  assign load_en   = (r_state == ST_LOAD) || (r_state == ST_WAIT_DONE) ||
                     (r_state == ST_CAPTURE);
  assign mem_we    = (r_state == ST_LOAD);
  assign mem_waddr = mem_we ? r_byte_cnt : 3'd0;
  assign mem_wdata = mem_we ? r_op[{w_wbyte_sel, 3'b000} +: 8] : 8'd0;
  assign transpose = r_transpose && busy;
  assign rsp_valid = (r_state == ST_RESPOND);
  assign rsp_id    = r_id && rsp_valid;
  assign rsp_err   = r_rsp_err && rsp_valid;
  assign rsp_data  = rsp_valid ? r_rsp_data : 64'd0;

endmodule
`default_nettype wire

// File: tb/tb_mmu_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmu_job_scheduler
// Description : Scoreboard testbench for mmu_job_scheduler.
//               - Directed jobs push their expected grant, memory writes and
//                 response into queues.
//               - A monitor pops and compares these whenever the DUT presents
//                 them.
//               - An MMU stub raises done 3 cycles after the last operand write
//                 and then streams 0x11..0x88.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmu_job_scheduler;

  localparam logic [63:0] c_RES = 64'h1122334455667788;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [63:0] operand0 = 64'd0;
  logic [63:0] operand1 = 64'd0;
  logic [1:0]  transpose_req = 2'b00;
  logic [1:0]  gnt;
  logic        mmu_rst, load_en, transpose, mem_we;
  logic [2:0]  mem_waddr;
  logic [7:0]  mem_wdata;
  logic        mmu_done = 1'b0;
  logic [7:0]  mmu_outdata = 8'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_id;
  logic [63:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  always #5 clk = ~clk;

  mmu_job_scheduler #(.TIMEOUT_CYC(64), .TO_W(7)) dut (
    .clk(clk), .rst(rst), .req(req), .operand0(operand0), .operand1(operand1),
    .transpose_req(transpose_req), .gnt(gnt), .mmu_rst(mmu_rst),
    .load_en(load_en), .transpose(transpose), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mmu_done(mmu_done),
    .mmu_outdata(mmu_outdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  logic [1:0]  q_gnt[$];
  logic [10:0] q_wr[$];
  logic [65:0] q_rsp[$];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: actual=no event required=event within bound", name);
  endtask

  task automatic push_job(input logic id, input logic [63:0] op, input logic err, input int nwr);
    q_gnt.push_back(id ? 2'b10 : 2'b01);
    for (int k = 0; k < nwr; k++) q_wr.push_back({3'(k), op[8*(7-k) +: 8]});
    if (nwr == 8) q_rsp.push_back({id, err, err ? 64'd0 : c_RES});
  endtask

  // MMU stub: it acts 2 time units into each cycle, after the stimulus has
  // driven its inputs.
  logic stub_hang = 1'b0;
  int   st_phase = 0;
  int   st_wait  = 0;
  int   st_idx   = 0;
  always @(posedge clk) begin
    #2;
    mmu_done = 1'b0;
    if (rst) begin
      st_phase = 0;
    end else begin
      if (st_phase == 1) begin
        st_wait--;
        if (st_wait == 0) begin
          mmu_done    = 1'b1;
          mmu_outdata = 8'h11;
          st_idx      = 1;
          st_phase    = 2;
        end
      end else if (st_phase == 2) begin
        mmu_outdata = 8'(8'h11 * (st_idx + 1));
        st_idx++;
        if (st_idx == 8) st_phase = 0;
      end
      if (mem_we && mem_waddr == 3'd7 && !stub_hang) begin
        st_phase = 1;
        st_wait  = 3;
      end
    end
  end

  // Monitor: compares every presented grant, write and response handshake
  // against the scoreboard.
  always @(negedge clk) begin
    if (gnt !== 2'b00) begin
      if (q_gnt.size() == 0) chk("gnt_unexpected", 72'(gnt), 72'd0);
      else chk("gnt", 72'(gnt), 72'(q_gnt.pop_front()));
    end
    if (mem_we === 1'b1) begin
      if (q_wr.size() == 0) chk("wr_unexpected", 72'({mem_waddr, mem_wdata}), 72'h7ff_dead);
      else chk("wr", 72'({mem_waddr, mem_wdata}), 72'(q_wr.pop_front()));
    end
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (q_rsp.size() == 0) chk("rsp_unexpected", 72'({rsp_id, rsp_err, rsp_data}), 72'd0);
      else chk("rsp", 72'({rsp_id, rsp_err, rsp_data}), 72'(q_rsp.pop_front()));
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_edge();
    rst = 1'b1; req = 2'b00; rsp_ready = 1'b1; transpose_req = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Returns at the negedge of the grant cycle.
  task automatic wait_gnt(input string name);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (gnt !== 2'b00) begin ok = 1; break; end
    end
    if (!ok) fail_timeout(name);
  endtask

  // Returns at the negedge of the first cycle with rsp_valid; n counts negedges.
  task automatic wait_valid(input string name, output int n);
    bit ok = 0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n++;
      if (rsp_valid === 1'b1) begin ok = 1; break; end
    end
    if (!ok) fail_timeout(name);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int tbad;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_busy", 72'(busy), 72'd0);
    chk("rst_mmu_rst", 72'(mmu_rst), 72'd1);
    chk("rst_outs", 72'({gnt, load_en, mem_we, transpose, rsp_valid, rsp_err, rsp_id}), 72'd0);
    chk("rst_rsp_data", 72'(rsp_data), 72'd0);

    // Single job from requester 0, exact timing
    drive_edge();
    operand0 = 64'h0100000105060708;
    req = 2'b01;
    push_job(1'b0, 64'h0100000105060708, 1'b0, 8);
    wait_gnt("t1_gnt");
    drive_edge();
    req = 2'b00;
    @(negedge clk);
    chk("t1_mmu_rst_T1", 72'({mmu_rst, mem_we, busy}), 72'b101);
    @(negedge clk);
    chk("t1_first_write_T2", 72'({mem_we, mem_waddr, load_en}), 72'b1_000_1);
    wait_valid("t1_rsp", n);
    chk("t1_rsp_latency", 72'(n + 2), 72'd20);
    chk("t1_load_en_respond", 72'(load_en), 72'd0);

    // Round-robin with both requesters held
    do_reset();
    operand0 = 64'h0011223344556677;
    operand1 = 64'h8899aabbccddeeff;
    req = 2'b11;
    push_job(1'b0, 64'h0011223344556677, 1'b0, 8);
    push_job(1'b1, 64'h8899aabbccddeeff, 1'b0, 8);
    push_job(1'b0, 64'h0011223344556677, 1'b0, 8);
    for (int j = 0; j < 3; j++) begin
      wait_valid("t2_rsp", n);
      chk("t2_no_gnt_in_hs", 72'(gnt), 72'd0);
      if (j < 2) begin
        @(negedge clk);
        chk("t2_gnt_after_hs", 72'(gnt), (j == 0) ? 72'd2 : 72'd1);
      end else begin
        drive_edge();
        req = 2'b00;
      end
    end

    // Timeout, then a normal job
    stub_hang = 1'b1;
    drive_edge();
    operand0 = 64'hcafef00d12345678;
    req = 2'b01;
    push_job(1'b0, 64'hcafef00d12345678, 1'b1, 8);
    wait_gnt("t3_gnt");
    drive_edge();
    req = 2'b00;
    wait_valid("t3_rsp", n);
    chk("t3_timeout_latency", 72'(n), 72'd74);
    chk("t3_err", 72'({rsp_err, rsp_data}), {7'd0, 1'b1, 64'd0});
    stub_hang = 1'b0;
    drive_edge();
    operand1 = 64'h0f1e2d3c4b5a6978;
    req = 2'b10;
    push_job(1'b1, 64'h0f1e2d3c4b5a6978, 1'b0, 8);
    wait_gnt("t3b_gnt");
    drive_edge();
    req = 2'b00;
    wait_valid("t3b_rsp", n);
    chk("t3b_err_clear", 72'({rsp_err, rsp_id}), 72'b01);

    // Back-pressure: rsp_ready low for 5 RESPOND cycles
    drive_edge();
    rsp_ready = 1'b0;
    operand0 = 64'h1020304050607080;
    req = 2'b01;
    push_job(1'b0, 64'h1020304050607080, 1'b0, 8);
    push_job(1'b0, 64'h1020304050607080, 1'b0, 8);
    wait_gnt("t4_gnt");
    wait_valid("t4_rsp", n);
    tbad = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== c_RES || rsp_id !== 1'b0 || gnt !== 2'b00) tbad++;
    end
    chk("t4_stall_stable", 72'(tbad), 72'd0);
    drive_edge();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_hs_cycle", 72'({rsp_valid, gnt}), 72'b100);
    @(negedge clk);
    chk("t4_gnt_after_hs", 72'({rsp_valid, gnt}), 72'b001);
    drive_edge();
    req = 2'b00;
    wait_valid("t4b_rsp", n);

    // Reset in the 4th LOAD cycle
    do_reset();
    operand0 = 64'haa55aa55aa55aa55;
    operand1 = 64'h5555555555555555;
    req = 2'b11;
    push_job(1'b0, 64'haa55aa55aa55aa55, 1'b0, 4);
    push_job(1'b0, 64'haa55aa55aa55aa55, 1'b0, 8);
    wait_gnt("t5_gnt");
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    drive_edge();
    @(negedge clk);
    chk("t5_after_rst", 72'({busy, mem_we, mmu_rst, rsp_valid, gnt}), 72'b00100_0);
    drive_edge();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_regrant", 72'(gnt), 72'd1);
    drive_edge();
    req = 2'b00;
    wait_valid("t5_rsp", n);

    // Transpose latched from requester 1
    drive_edge();
    operand1 = 64'h7766554433221100;
    transpose_req = 2'b10;
    req = 2'b10;
    push_job(1'b1, 64'h7766554433221100, 1'b0, 8);
    wait_gnt("t6_gnt");
    chk("t6_transpose_at_gnt", 72'(transpose), 72'd0);
    drive_edge();
    req = 2'b00;
    transpose_req = 2'b00;
    tbad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (transpose !== 1'b1) tbad++;
      if (rsp_valid === 1'b1) break;
    end
    chk("t6_transpose_held", 72'(tbad), 72'd0);
    @(negedge clk);
    chk("t6_transpose_idle", 72'({transpose, busy}), 72'd0);

    repeat (5) @(negedge clk);
    chk("q_gnt_left", 72'(q_gnt.size()), 72'd0);
    chk("q_wr_left", 72'(q_wr.size()), 72'd0);
    chk("q_rsp_left", 72'(q_rsp.size()), 72'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mmu_job_scheduler.md
Name: mmu_job_scheduler

Overview:
Arbitrates two host requesters for the single 2x2 matrix-multiply unit (control unit, operand memory, systolic array). Each accepted job is sequenced end to end, one at a time:
- Reset the MMU control path.
- Stream 8 operand bytes into operand memory while asserting load_en.
- Wait for mmu_done.
- Capture the 8 serialized result bytes.
- Return them to the winning requester.

Parameters:
TIMEOUT_CYC, 64, max cycles in WAIT_DONE before the job is aborted with an error
TO_W, 7, width of the timeout counter; must hold TIMEOUT_CYC

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req  in  2  per-requester job request; level, held until granted
operand0  in  64  requester 0 job: [63:32]=w0..w3, [31:0]=x0..x3, MSB byte first
operand1  in  64  requester 1 job, same layout
transpose_req  in  2  per-requester transpose flag
gnt  out  2  one-hot, 1-cycle pulse; operand and transpose are sampled this cycle
mmu_rst  out  1  reset to MMU control path
load_en  out  1  MMU load enable
transpose  out  1  transpose flag to MMU, held for the whole job
mem_we  out  1  operand memory write strobe
mem_waddr  out  3  operand memory write address
mem_wdata  out  8  operand memory write data
mmu_done  in  1  MMU result-valid indication
mmu_outdata  in  8  serialized MMU result byte
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  1  requester index of the response
rsp_data  out  64  8 captured result bytes, first byte in [63:56]
rsp_err  out  1  timeout abort; rsp_data=0 when set
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: state IDLE; all outputs 0 except mmu_rst=1; RR pointer favours requester 0.
- Reset mid-job: abandons the job with no response. The pending req is re-arbitrated after reset.
- IDLE:
  - Grant when any req is high. If both are high, grant the requester not granted last (round-robin).
  - The grant cycle pulses gnt and latches the operand word, transpose flag and id.
  - Next state RST_MMU.
- RST_MMU: 1 cycle, mmu_rst=1, then LOAD.
- LOAD: exactly 8 cycles with mem_we=1, load_en=1 and mem_waddr=0..7.
  - mem_wdata = latched word byte k at addr k: addr 0 carries [63:56], addr 7 carries [7:0].
  - Timing: grant at T, mmu_rst at T+1, writes at T+2..T+9.
- WAIT_DONE:
  - load_en stays 1 (MMU requires it held); mem_we=0.
  - Timeout counter runs from 0.
  - On the first cycle mmu_done=1, sample mmu_outdata as byte 0 into [63:56], then go to CAPTURE.
  - If the counter reaches TIMEOUT_CYC-1 without mmu_done, go to RESPOND with rsp_err=1 and rsp_data=0.
- CAPTURE:
  - 7 further cycles sample bytes 1..7 into successive lower bytes, regardless of mmu_done.
  - Then go to RESPOND; load_en drops to 0 on entry to RESPOND.
- RESPOND:
  - rsp_valid=1; rsp_id, rsp_data and rsp_err are stable until rsp_valid && rsp_ready, then IDLE.
  - rsp_ready high on the first RESPOND cycle completes in 1 cycle.
- Timing constraints:
  - No grant while busy; new req is ignored until IDLE.
  - A new grant is possible in the cycle after the handshake, never in the same cycle.
- req dropped after grant: no effect. A req dropped before grant is simply not granted.
- transpose output = latched flag from grant through RESPOND; 0 in IDLE.

Decomposition:
- Package mmu_sched_pkg:
  - state enum: IDLE, RST_MMU, LOAD, WAIT_DONE, CAPTURE, RESPOND.
  - constants: NUM_OPERAND_BYTES=8, NUM_RESULT_BYTES=8.
- One sub-module rr_arb2 (2-way round-robin arbiter with last-grant pointer, update on grant).
- Byte counter and timeout counter stay inline.

Test Plan:
1. Single job, req=2'b01, operand0=0x0100000105060708, with an MMU stub that raises done 3 cycles after the last write and then emits 0x11..0x88:
   - gnt=01 at T; mem writes 01,00,00,01,05,06,07,08 at T+2..T+9.
   - rsp_data=0x1122334455667788, rsp_id=0, rsp_err=0.
2. Both req high from reset: grants alternate 0,1,0 across three jobs. With req=11 held, rsp_id sequence is 0,1,0.
3. Stub never asserts done: after TIMEOUT_CYC=64 WAIT_DONE cycles, rsp_valid=1, rsp_err=1, rsp_data=0; the next job runs normally.
4. rsp_ready held low 5 cycles in RESPOND: rsp_valid, rsp_data and rsp_id stay stable; no gnt until 1 cycle after the handshake.
5. rst asserted in the 4th LOAD cycle: the next cycle shows IDLE, busy=0, mem_we=0, mmu_rst=1, and no rsp_valid. A held req is granted 1 cycle after rst deasserts, with requester 0 priority.
6. transpose_req=2'b10 with req=10: transpose=1 from T+1 through RESPOND, then 0.
